// File: rtl/crisp_pkg.sv
// Shared types and constants for the crisp pipeline front end.
// fetch_pkt_t is the {pc, instr} pair passed from fetch to decode.
package crisp_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch packets with flush and a registered head entry.
// The head register lets decode see the oldest entry straight from a flop.
module fetch_fifo
    import crisp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_pkt_t       push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_pkt_t       head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    fetch_pkt_t       mem_q [DEPTH];
    fetch_pkt_t       mem_d [DEPTH];
    fetch_pkt_t       head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = head_q;
    assign count   = count_q;

    // The head follows the entry at the post-update read pointer; a push
    // into an empty (or just-drained) FIFO bypasses the storage array.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if (do_push && (count_q == CNT_W'(do_pop))) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assert property (@(posedge clk) disable iff (rst) do_push |-> (!full || do_pop));

endmodule

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, buffers responses and hands {pc, instr} to decode.
module stage_fetch
    import crisp_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic [31:0]      redirect_target;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    fetch_pkt_t       push_pkt;
    fetch_pkt_t       head;

    // Every outstanding request already owns a FIFO slot, so responses never overflow.
    assign in_use          = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid  = !rst && !redirect_valid && (in_use < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_req_addr   = pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = redirect_pc & ~32'h3;
    assign push_pkt        = '{pc: resp_pc_q, instr: imem_resp_data};

    assign if_valid = !fifo_empty;
    assign pop      = if_valid && if_ready;
    assign if_instr = if_valid ? head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? head.pc : RESET_PC;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        push          = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
        if (redirect_valid) begin
            pc_d      = redirect_target;
            resp_pc_d = redirect_target;
            discard_d = outstanding_q - CNT_W'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_resp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_pkt),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (rst) imem_resp_valid |-> (outstanding_q != '0));
    assert property (@(posedge clk) disable iff (rst)
        (imem_req_valid && !imem_req_ready) |=> $stable(imem_req_addr));

endmodule

// File: tb/tb_stage_fetch.sv
// Randomized bench for stage_fetch against a transaction-level model of the
// fetch stream: expected request addresses, delivered PCs and credit usage.
module tb_stage_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       pending[$];
    int          buffered;
    logic [31:0] exp_pc;
    logic [31:0] req_pc;
    logic [31:0] last_hs_pc;
    int          cyc;
    int          last_due;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          fire_count;
    int          hs_count;
    int          n_checks;
    int          n_errors;

    stage_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare combinational and
    // registered outputs against the model, then advance the model.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit rdy, input bit ifr);
        bit    resp;
        bit    exp_req;
        int    due;
        pend_t front;
        @(negedge clk);
        cyc++;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if_ready       = ifr;
        resp = (pending.size() > 0) && (pending[0].due == cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? memWord(pending[0].addr) : 32'h0;
        #1;
        exp_req = !redir && ((pending.size() + buffered) < DEPTH);
        checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        checkOutput("if_valid", {31'b0, if_valid}, {31'b0, buffered > 0});
        if (buffered > 0 && ifr) begin
            checkOutput("if_pc", if_pc, exp_pc);
            checkOutput("if_instr", if_instr, memWord(exp_pc));
            last_hs_pc = if_pc;
            exp_pc     = exp_pc + 32'd4;
            buffered--;
            hs_count++;
        end
        if (exp_req && rdy) begin
            checkOutput("req_addr", imem_req_addr, req_pc);
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{req_pc, due, 1'b0});
            req_pc = req_pc + 32'd4;
            fire_count++;
        end
        if (resp) begin
            front = pending.pop_front();
            if (!front.stale && !redir) buffered++;
        end
        if (redir) begin
            foreach (pending[i]) pending[i].stale = 1'b1;
            buffered = 0;
            req_pc   = rpc & ~32'h3;
            exp_pc   = rpc & ~32'h3;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        cyc++;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        if_ready        = 1'b0;
        #1;
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        pending.delete();
        buffered = 0;
        exp_pc   = RESET_PC;
        req_pc   = RESET_PC;
        last_due = cyc;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        #1;
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
        checkOutput("rst_if_instr", if_instr, NOP);
        checkOutput("rst_if_pc", if_pc, RESET_PC);
        checkOutput("rst_first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("rst_first_addr", imem_req_addr, RESET_PC);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        bit seen;
        repeat (2) @(posedge clk);

        // Streaming with single-cycle memory and an always-ready decoder.
        doReset();
        lat_lo = 1; lat_hi = 1;
        start = hs_count;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t1_throughput", 32'(hs_count - start), 32'd18);

        // Decoder stalled: credit limits requests to the buffer depth.
        doReset();
        start = fire_count;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("t2_fires", 32'(fire_count - start), 32'd4);
        checkOutput("t2_stalled_req", {31'b0, imem_req_valid}, 32'h0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with two requests in flight on a slow memory.
        doReset();
        lat_lo = 3; lat_hi = 3;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        start = hs_count;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            seen = (hs_count != start);
        end
        checkOutput("t3_hs_seen", {31'b0, seen}, 32'h1);
        checkOutput("t3_first_pc", last_hs_pc, 32'h100);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect coinciding with a response; low address bits ignored.
        doReset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h203, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_next_addr", imem_req_addr, 32'h200);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Reset while the buffer holds three entries.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // PC wrap from the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic: latency, back-pressure, redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            if (i % 400 == 0) begin
                lat_lo = 1;
                lat_hi = $urandom_range(4, 1);
            end
            if ($urandom_range(299, 0) == 0) begin
                doReset();
            end else begin
                rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                   : $urandom;
                applyStimulus($urandom_range(19, 0) == 0, rpc,
                              $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
